// File: rtl/req_queue_pkg.sv
// Shared constants and helpers for the per-port request queue.
// The optional starvation tracker is enabled with REQ_QUEUE_STARVE_EN.
package req_queue_pkg;

    localparam int DATA_WIDTH   = 132;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 15;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/req_queue_if.sv
// Requester/scheduler-facing bundle of the request queue. The urgent flag
// only exists when REQ_QUEUE_STARVE_EN is defined.
interface req_queue_if
    import req_queue_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int depth      = DEPTH
) ();

    localparam int ptr_bits = clog2(depth);

    logic                  push_valid;
    logic                  push_ready;
    logic [data_width-1:0] push_data;
    logic                  req;
    logic                  serv;
    logic [data_width-1:0] data_OUT;
    logic [ptr_bits:0]     count;
    logic                  full;
    logic                  empty;
`ifdef REQ_QUEUE_STARVE_EN
    logic                  urgent;

    modport slave (
        input  push_valid, push_data, serv,
        output push_ready, req, data_OUT, count, full, empty, urgent
    );

    modport master (
        output push_valid, push_data, serv,
        input  push_ready, req, data_OUT, count, full, empty, urgent
    );
`else
    modport slave (
        input  push_valid, push_data, serv,
        output push_ready, req, data_OUT, count, full, empty
    );

    modport master (
        output push_valid, push_data, serv,
        input  push_ready, req, data_OUT, count, full, empty
    );
`endif

endinterface

// File: rtl/req_queue_ram.sv
// Entry storage for req_queue: synchronous write, asynchronous read, no reset.
module req_queue_ram
    import req_queue_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int depth      = DEPTH,
    parameter int ptr_bits   = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ptr_bits-1:0]   waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [ptr_bits-1:0]   raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/req_queue.sv
// Per-port FIFO of request words feeding one scheduler leaf (req/serv).
// Define REQ_QUEUE_STARVE_EN to add the head-starvation counter and urgent flag.
module req_queue
    import req_queue_pkg::*;
#(
    parameter int data_width   = DATA_WIDTH,
    parameter int depth        = DEPTH
`ifdef REQ_QUEUE_STARVE_EN
    ,
    parameter int starve_limit = STARVE_LIMIT
`endif
) (
    input  logic      clk,
    input  logic      rst,
    req_queue_if.slave q
);

    localparam int ptr_bits = clog2(depth);
    localparam logic [ptr_bits-1:0] ptr_one    = ptr_bits'(1);
    localparam logic [ptr_bits:0]   count_one  = (ptr_bits + 1)'(1);
    localparam logic [ptr_bits:0]   full_count = (ptr_bits + 1)'(depth);

    logic [ptr_bits-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ptr_bits-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [ptr_bits:0]     count_reg, count_next;
    logic                  full_w, empty_w, push_ready_w;
    logic                  push_fire, pop_fire;
    logic [data_width-1:0] rd_data;

    // Flags decode only the count register, so push_ready never depends on serv.
    assign full_w       = (count_reg == full_count);
    assign empty_w      = (count_reg == '0);
    assign push_ready_w = !rst && !full_w;
    assign push_fire    = q.push_valid && push_ready_w;
    assign pop_fire     = !empty_w && q.serv;

    assign q.push_ready = push_ready_w;
    assign q.req        = !empty_w;
    assign q.full       = full_w;
    assign q.empty      = empty_w;
    assign q.count      = count_reg;
    assign q.data_OUT   = empty_w ? '0 : rd_data;

    req_queue_ram #(
        .data_width (data_width),
        .depth      (depth),
        .ptr_bits   (ptr_bits)
    ) u_ram (
        .clk   (clk),
        .we    (push_fire),
        .waddr (wr_ptr_reg),
        .wdata (q.push_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_fire) begin
            wr_ptr_next = wr_ptr_reg + ptr_one;
        end
        if (pop_fire) begin
            rd_ptr_next = rd_ptr_reg + ptr_one;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + count_one;
            2'b01:   count_next = count_reg - count_one;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

`ifdef REQ_QUEUE_STARVE_EN
    localparam int wait_bits = clog2(starve_limit + 1);
    localparam logic [wait_bits-1:0] wait_max = wait_bits'(starve_limit);
    localparam logic [wait_bits-1:0] wait_one = wait_bits'(1);

    logic [wait_bits-1:0] wait_reg, wait_next;
    logic                 urgent_reg;

    // Counts cycles the current head has been offered without a grant.
    always_comb begin
        wait_next = wait_reg;
        if (pop_fire || empty_w) begin
            wait_next = '0;
        end else if (!q.serv && (wait_reg != wait_max)) begin
            wait_next = wait_reg + wait_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg   <= '0;
            urgent_reg <= 1'b0;
        end else begin
            wait_reg   <= wait_next;
            urgent_reg <= (wait_next == wait_max);
        end
    end

    assign q.urgent = urgent_reg;
`endif

endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: vector table plus reset and starvation sequences.
// The starvation sequence runs only when REQ_QUEUE_STARVE_EN is defined.
module tb_req_queue;
    import req_queue_pkg::*;

    localparam int DW = DATA_WIDTH;

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          srv;
        logic          e_req;
        logic [DW-1:0] e_data;
        logic [2:0]    e_count;
        logic          e_full;
        logic          e_empty;
        logic          e_pr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    req_queue_if #(.data_width(DW), .depth(DEPTH)) bus ();

    req_queue dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [DW-1:0] pd, input logic srv,
                       input logic e_req, input logic [DW-1:0] e_data, input int e_count,
                       input logic e_full, input logic e_empty, input logic e_pr);
        vec_t v;
        v.pv = pv; v.pd = pd; v.srv = srv;
        v.e_req = e_req; v.e_data = e_data; v.e_count = 3'(e_count);
        v.e_full = e_full; v.e_empty = e_empty; v.e_pr = e_pr;
        vecs.push_back(v);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req"},        DW'(bus.req),        DW'(1'b0));
        check({tag, ".data"},       bus.data_OUT,        '0);
        check({tag, ".count"},      DW'(bus.count),      '0);
        check({tag, ".full"},       DW'(bus.full),       DW'(1'b0));
        check({tag, ".empty"},      DW'(bus.empty),      DW'(1'b1));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.serv       = 1'b0;

        // Expected state after each edge, written out by hand.
        add(1, 'hA5, 0,  1, 'hA5, 1, 0, 0, 1);
        add(0, 0,    1,  0, 0,    0, 0, 1, 1);
        add(0, 0,    1,  0, 0,    0, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            add(1, DW'(k), 0, 1, DW'(1), k, k == 4, 0, k != 4);
        end
        add(1, 5, 0,  1, 1, 4, 1, 0, 0);
        add(1, 5, 1,  1, 2, 3, 0, 0, 1);
        add(0, 0, 1,  1, 3, 2, 0, 0, 1);
        add(0, 0, 1,  1, 4, 1, 0, 0, 1);
        add(0, 0, 1,  0, 0, 0, 0, 1, 1);
        for (int v = 1; v <= 10; v++) begin
            add(1, DW'(v), 1, 1, DW'(v), 1, 0, 0, 1);
        end
        add(0, 0, 1,  0, 0, 0, 0, 1, 1);

        #1;
        check("rst.push_ready", DW'(bus.push_ready), DW'(1'b0));
        check_idle("rst");
`ifdef REQ_QUEUE_STARVE_EN
        check("rst.urgent", DW'(bus.urgent), DW'(1'b0));
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("release.push_ready", DW'(bus.push_ready), DW'(1'b1));

        foreach (vecs[i]) begin
            bus.push_valid = vecs[i].pv;
            bus.push_data  = vecs[i].pd;
            bus.serv       = vecs[i].srv;
            @(posedge clk);
            #1;
            $display("vec %0d push=%0b data=%0h serv=%0b -> req=%0b head=%0h count=%0d",
                     i, vecs[i].pv, vecs[i].pd, vecs[i].srv, bus.req, bus.data_OUT, bus.count);
            check($sformatf("v%0d.req", i),   DW'(bus.req),        DW'(vecs[i].e_req));
            check($sformatf("v%0d.data", i),  bus.data_OUT,        vecs[i].e_data);
            check($sformatf("v%0d.count", i), DW'(bus.count),      DW'(vecs[i].e_count));
            check($sformatf("v%0d.full", i),  DW'(bus.full),       DW'(vecs[i].e_full));
            check($sformatf("v%0d.empty", i), DW'(bus.empty),      DW'(vecs[i].e_empty));
            check($sformatf("v%0d.ready", i), DW'(bus.push_ready), DW'(vecs[i].e_pr));
        end

        // Asynchronous reset with three entries queued.
        bus.serv = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = DW'(k * 'h11);
            @(posedge clk);
            #1;
        end
        bus.push_valid = 1'b0;
        $display("midrst fill count=%0d head=%0h", bus.count, bus.data_OUT);
        check("midrst.count_before", DW'(bus.count), DW'(3));
        #2 rst = 1'b1;
        #1;
        $display("midrst asserted count=%0d req=%0b", bus.count, bus.req);
        check_idle("midrst");
        check("midrst.push_ready", DW'(bus.push_ready), DW'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst.release_ready", DW'(bus.push_ready), DW'(1'b1));
        bus.push_valid = 1'b1;
        bus.push_data  = DW'('h77);
        @(posedge clk);
        #1;
        bus.push_valid = 1'b0;
        $display("midrst push 77 head=%0h count=%0d", bus.data_OUT, bus.count);
        check("midrst.new_head", bus.data_OUT, DW'('h77));
        check("midrst.new_count", DW'(bus.count), DW'(1));
        bus.serv = 1'b1;
        @(posedge clk);
        #1;
        bus.serv = 1'b0;
        check_idle("midrst.drain");

`ifdef REQ_QUEUE_STARVE_EN
        bus.push_valid = 1'b1;
        bus.push_data  = DW'('h5A);
        @(posedge clk);
        #1;
        bus.push_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
        end
        $display("starve 14 cycles urgent=%0b", bus.urgent);
        check("starve.urgent14", DW'(bus.urgent), DW'(1'b0));
        @(posedge clk);
        #1;
        $display("starve 15 cycles urgent=%0b", bus.urgent);
        check("starve.urgent15", DW'(bus.urgent), DW'(1'b1));
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
        end
        check("starve.urgent_hold", DW'(bus.urgent), DW'(1'b1));
        bus.serv = 1'b1;
        @(posedge clk);
        #1;
        bus.serv = 1'b0;
        $display("starve serv urgent=%0b empty=%0b", bus.urgent, bus.empty);
        check("starve.urgent_clear", DW'(bus.urgent), DW'(1'b0));
        check("starve.empty", DW'(bus.empty), DW'(1'b1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_queue.md
# req_queue

Per-port request buffer sitting directly upstream of the access scheduler tree. Each requester (core or interconnect port) pushes fixed-width request words into its own `req_queue`. The queue presents the oldest word to one scheduler leaf as a `req` flag plus data, and pops it when the tree returns the matching `serv` grant. Requesters can therefore issue back-to-back without stalling on arbitration conflicts, and grants are consumed in FIFO order.

## Interface
- `data_width`, 132: request word width; matches the scheduler data path.
- `depth`, 4: number of entries; power of two, minimum 2.
- `ptr_bits`, clog2(depth): read/write pointer width; derived, not overridden.
- `starve_limit`, 15: cycles the head may wait ungranted before `urgent` rises (only with `REQ_QUEUE_STARVE_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `push_valid`  in  1  requester offers `push_data`.
- `push_ready`  out  1  queue accepts this cycle; equals !full, forced 0 while `rst` is high.
- `push_data`  in  data_width  request word.
- `req`  out  1  head entry valid; wires to a scheduler leaf `req` input.
- `serv`  in  1  grant from the scheduler for this leaf; combinational, same cycle as `req`.
- `data_OUT`  out  data_width  head entry; all-zero when empty.
- `count`  out  ptr_bits+1  occupancy, 0..depth.
- `full`  out  1  count == depth.
- `empty`  out  1  count == 0.
- `urgent`  out  1  head starved (macro only; otherwise port absent).

## Operation
- Push fires at posedge when `push_valid && push_ready`. Word is written at `wr_ptr`, then `wr_ptr` increments modulo depth.
- Pop fires at posedge when `req && serv`. `rd_ptr` increments modulo depth.
- `serv` while `req` is low is ignored; no state change.
- Push and pop in the same cycle: both pointers advance, `count` unchanged.
- Full: `push_ready` is 0 even if a pop fires this cycle. There is no full-bypass, so `push_ready` stays a pure register decode.
- Empty: there is no fall-through. A pushed word is never visible on `data_OUT` in its own push cycle.
- Pointers wrap naturally. `count` is tracked explicitly and is not derived from pointer difference.
- `req` = !empty. `data_OUT` = mem[rd_ptr] gated by !empty.
- Data is never modified, reordered or dropped.

## Timing
- Reset values: `count`=0, pointers=0, `req`=0, `data_OUT`=0, `empty`=1, `full`=0, `urgent`=0. `push_ready`=0 while `rst` is high, and 1 on the first cycle after release.
- Reset mid-operation: all entries are discarded immediately (asynchronous). Storage contents need not be cleared; only the pointers and count are reset.
- Latency push→`req`: 1 cycle (a push at edge N gives `req`=1 after edge N).
- Latency grant→next head: a pop at edge N presents the next entry, or `req`=0, after edge N.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.

## Configuration
- `REQ_QUEUE_STARVE_EN` defined:
  - A wait counter of clog2(starve_limit+1) bits increments each cycle with `req && !serv` and saturates at `starve_limit`.
  - The counter clears on any pop, and whenever the queue is empty.
  - `urgent` = (counter == starve_limit), registered. It feeds the scheduler's future priority override.
- Macro undefined: the counter and the `urgent` port are removed.

## Structure
- Package `req_queue_pkg`:
  - `DATA_WIDTH` = 132, shared with the scheduler tree.
  - Default `DEPTH` and `STARVE_LIMIT` constants.
  - A clog2 helper function.
- One sub-module, `req_queue_ram`: depth×data_width register array with synchronous write and asynchronous read, no reset.
- Control logic (pointers, count, flags, starve counter) lives in `req_queue`.

## Test plan
- Reset then push 0xA5 (zero-extended) at cycle 1: `req`=1, `data_OUT`=0xA5, `count`=1 at cycle 2; `serv`=1 at cycle 2 gives `req`=0, `count`=0 at cycle 3.
- Push 1,2,3,4 with `serv`=0: `full`=1, `push_ready`=0, a fifth push of 5 is not accepted; then `serv` held for 4 cycles outputs 1,2,3,4 in order, then `empty`=1.
- Depth=4, continuous push and `serv` for 10 cycles (values 1..10): every value appears exactly once in order, `count` stays at 1, and the pointers wrap twice.
- `serv`=1 while empty: no pointer change, `count` stays 0, `data_OUT`=0.
- Queue holds 3 entries, assert `rst` mid-cycle: outputs go to reset values before the next edge; a push after release returns that new word first.
- With `REQ_QUEUE_STARVE_EN`, head waits ungranted: `urgent`=1 after 15 cycles and stays high; one `serv` clears it the next cycle.
